// File: rtl/demux_lane_deserializer_if.sv
// Bit-strobe input and valid/ready word output of the lane deserializer.
// The slave modport is the deserializer's view; master is the driver/consumer view.
interface demux_lane_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             bit_vld;
  logic [1:0]       sel;
  logic [3:0]       lanes;
  logic             word_vld;
  logic             word_rdy;
  logic [WIDTH-1:0] word_data;
  logic [1:0]       word_lane;
  logic [3:0]       ovf;
  logic             clr_ovf;

  modport slave (
    input  bit_vld, sel, lanes, word_rdy, clr_ovf,
    output word_vld, word_data, word_lane, ovf
  );

  modport master (
    output bit_vld, sel, lanes, word_rdy, clr_ovf,
    input  word_vld, word_data, word_lane, ovf
  );
endinterface

// File: rtl/demux_lane_deserializer.sv
// Four-lane serial-to-parallel deserializer behind a 1x4 demux. Each lane has a
// shift register and a one-word hold slot; a round-robin arbiter feeds one output.
module demux_lane_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  demux_lane_deserializer_if.slave   bus
);

  localparam int            NL       = 4;
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sh_q  [NL];
  logic [WIDTH-1:0] sh_d  [NL];
  logic [CW-1:0]    cnt_q [NL];
  logic [CW-1:0]    cnt_d [NL];
  logic [WIDTH-1:0] hd_q  [NL];
  logic [WIDTH-1:0] hd_d  [NL];
  logic [NL-1:0]    hf_q, hf_d;
  logic [NL-1:0]    ovf_q, ovf_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             word_vld_q, word_vld_d;
  logic [WIDTH-1:0] word_data_q, word_data_d;
  logic [1:0]       word_lane_q, word_lane_d;

  logic             load;
  logic             done;
  logic [WIDTH-1:0] shifted;
  logic             gnt_vld;
  logic [1:0]       gnt_lane;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic             b);
    if (MSB_FIRST) return {cur[WIDTH-2:0], b};
    else           return {b, cur[WIDTH-1:1]};
  endfunction

  // Round-robin search starting at ptr, wrapping modulo 4.
  always_comb begin : grant_search
    logic [1:0] idx;
    gnt_vld  = 1'b0;
    gnt_lane = ptr_q;
    idx      = ptr_q;
    for (int i = 0; i < NL; i++) begin
      idx = ptr_q + 2'(i);
      if (!gnt_vld && hf_q[idx]) begin
        gnt_vld  = 1'b1;
        gnt_lane = idx;
      end
    end
  end

  always_comb begin
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    hd_d        = hd_q;
    hf_d        = hf_q;
    ovf_d       = bus.clr_ovf ? '0 : ovf_q;
    ptr_d       = ptr_q;
    word_vld_d  = word_vld_q;
    word_data_d = word_data_q;
    word_lane_d = word_lane_q;
    load        = !word_vld_q || bus.word_rdy;
    shifted     = shift_in(sh_q[bus.sel], bus.lanes[bus.sel]);
    done        = bus.bit_vld && (cnt_q[bus.sel] == CNT_LAST);

    if (load) begin
      if (gnt_vld) begin
        word_vld_d     = 1'b1;
        word_data_d    = hd_q[gnt_lane];
        word_lane_d    = gnt_lane;
        hf_d[gnt_lane] = 1'b0;
        ptr_d          = gnt_lane + 2'd1;
      end else begin
        word_vld_d = 1'b0;
      end
    end

    // hf_d already reflects a same-cycle drain, so a draining slot accepts the new word.
    if (bus.bit_vld) begin
      if (done) begin
        sh_d[bus.sel]  = '0;
        cnt_d[bus.sel] = '0;
        if (!hf_d[bus.sel]) begin
          hd_d[bus.sel] = shifted;
          hf_d[bus.sel] = 1'b1;
        end else begin
          ovf_d[bus.sel] = 1'b1;
        end
      end else begin
        sh_d[bus.sel]  = shifted;
        cnt_d[bus.sel] = cnt_q[bus.sel] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NL; l++) begin
        sh_q[l]  <= '0;
        cnt_q[l] <= '0;
        hd_q[l]  <= '0;
      end
      hf_q        <= '0;
      ovf_q       <= '0;
      ptr_q       <= '0;
      word_vld_q  <= 1'b0;
      word_data_q <= '0;
      word_lane_q <= '0;
    end else begin
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      hd_q        <= hd_d;
      hf_q        <= hf_d;
      ovf_q       <= ovf_d;
      ptr_q       <= ptr_d;
      word_vld_q  <= word_vld_d;
      word_data_q <= word_data_d;
      word_lane_q <= word_lane_d;
    end
  end

  assign bus.word_vld  = word_vld_q;
  assign bus.word_data = word_data_q;
  assign bus.word_lane = word_lane_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_demux_lane_deserializer.sv
// Directed bench for demux_lane_deserializer: an MSB-first and an LSB-first
// instance share stimulus; the LSB-first one is checked in the vector table only.
module tb_demux_lane_deserializer;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_vld;
  logic [1:0] sel;
  logic [3:0] lanes;
  logic       word_rdy;
  logic       clr_ovf;

  always #5 clk = ~clk;

  demux_lane_deserializer_if #(.WIDTH(W)) bm ();
  demux_lane_deserializer_if #(.WIDTH(W)) bl ();

  assign bm.bit_vld  = bit_vld;
  assign bm.sel      = sel;
  assign bm.lanes    = lanes;
  assign bm.word_rdy = word_rdy;
  assign bm.clr_ovf  = clr_ovf;
  assign bl.bit_vld  = bit_vld;
  assign bl.sel      = sel;
  assign bl.lanes    = lanes;
  assign bl.word_rdy = word_rdy;
  assign bl.clr_ovf  = clr_ovf;

  demux_lane_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .bus(bm)
  );
  demux_lane_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .bus(bl)
  );

  typedef struct {
    logic [1:0] lane;
    logic [7:0] pat;    // pat[7] is sent first
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  vec_t vecs [5];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    bit_vld  = 1'b0;
    sel      = 2'd0;
    lanes    = 4'b0;
    word_rdy = 1'b1;
    clr_ovf  = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Non-selected lanes carry the opposite value so stray sampling shows up.
  task automatic send_bit(input logic [1:0] l, input logic b);
    @(negedge clk);
    bit_vld = 1'b1;
    sel     = l;
    lanes   = b ? (4'b0001 << l) : ~(4'b0001 << l);
    @(posedge clk);
    #1;
    bit_vld = 1'b0;
    lanes   = 4'b0;
  endtask

  task automatic send_word(input logic [1:0] l, input logic [7:0] pat);
    for (int i = 7; i >= 0; i--) send_bit(l, pat[i]);
  endtask

  initial begin
    logic [7:0] p;
    logic [1:0] rr_lane [3];
    logic [7:0] rr_data [3];

    vecs[0] = '{lane: 2'd2, pat: 8'hA5, exp_m: 8'hA5, exp_l: 8'hA5};
    vecs[1] = '{lane: 2'd0, pat: 8'hC0, exp_m: 8'hC0, exp_l: 8'h03};
    vecs[2] = '{lane: 2'd3, pat: 8'h80, exp_m: 8'h80, exp_l: 8'h01};
    vecs[3] = '{lane: 2'd1, pat: 8'hF0, exp_m: 8'hF0, exp_l: 8'h0F};
    vecs[4] = '{lane: 2'd2, pat: 8'h6D, exp_m: 8'h6D, exp_l: 8'hB6};

    do_reset();
    chk("rst_vld",  32'(bm.word_vld),  32'h0);
    chk("rst_data", 32'(bm.word_data), 32'h0);
    chk("rst_lane", 32'(bm.word_lane), 32'h0);
    chk("rst_ovf",  32'(bm.ovf),       32'h0);

    // Single words, word_rdy=1: vld rises two edges after the final strobe, lasts one cycle.
    for (int v = 0; v < 5; v++) begin
      send_word(vecs[v].lane, vecs[v].pat);
      chk("tbl_vld_early", 32'(bm.word_vld), 32'h0);
      @(posedge clk); #1;
      chk("tbl_vld",    32'(bm.word_vld),  32'h1);
      chk("tbl_data_m", 32'(bm.word_data), 32'(vecs[v].exp_m));
      chk("tbl_lane_m", 32'(bm.word_lane), 32'(vecs[v].lane));
      chk("tbl_data_l", 32'(bl.word_data), 32'(vecs[v].exp_l));
      chk("tbl_lane_l", 32'(bl.word_lane), 32'(vecs[v].lane));
      @(posedge clk); #1;
      chk("tbl_vld_drop",   32'(bm.word_vld), 32'h0);
      chk("tbl_vld_drop_l", 32'(bl.word_vld), 32'h0);
    end
    chk("tbl_ovf", 32'(bm.ovf), 32'h0);

    // Asynchronous reset with a held output word and a partial lane-1 word.
    do_reset();
    word_rdy = 1'b0;
    send_word(2'd2, 8'hA5);
    @(posedge clk); #1;
    chk("mid_held_vld", 32'(bm.word_vld), 32'h1);
    for (int i = 0; i < 5; i++) send_bit(2'd1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld",  32'(bm.word_vld),  32'h0);
    chk("mid_rst_data", 32'(bm.word_data), 32'h0);
    chk("mid_rst_lane", 32'(bm.word_lane), 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    word_rdy = 1'b1;
    send_word(2'd1, 8'h5A);
    @(posedge clk); #1;
    chk("mid_word_vld",  32'(bm.word_vld),  32'h1);
    chk("mid_word_data", 32'(bm.word_data), 32'h5A);
    chk("mid_word_lane", 32'(bm.word_lane), 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("mid_single_word", 32'(bm.word_vld), 32'h0);
    end
    chk("mid_ovf", 32'(bm.ovf), 32'h0);

    // Round-robin: lane 0 takes the output, then lanes 0,1,3 pend; ptr=1 gives 1,3,0.
    do_reset();
    word_rdy = 1'b0;
    send_word(2'd0, 8'h01);
    send_word(2'd0, 8'h02);
    send_word(2'd1, 8'h10);
    send_word(2'd3, 8'h30);
    chk("rr_held_vld",  32'(bm.word_vld),  32'h1);
    chk("rr_held_data", 32'(bm.word_data), 32'h01);
    chk("rr_held_lane", 32'(bm.word_lane), 32'h0);
    chk("rr_ovf",       32'(bm.ovf),       32'h0);
    rr_lane  = '{2'd1, 2'd3, 2'd0};
    rr_data  = '{8'h10, 8'h30, 8'h02};
    word_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rr_vld",  32'(bm.word_vld),  32'h1);
      chk("rr_lane", 32'(bm.word_lane), 32'(rr_lane[k]));
      chk("rr_data", 32'(bm.word_data), 32'(rr_data[k]));
    end
    @(posedge clk); #1;
    chk("rr_idle", 32'(bm.word_vld), 32'h0);

    // Backpressure: third lane-1 word is dropped and flagged.
    do_reset();
    word_rdy = 1'b0;
    send_word(2'd1, 8'h11);
    send_word(2'd1, 8'h22);
    send_word(2'd1, 8'h33);
    @(posedge clk); #1;
    chk("bp_ovf",  32'(bm.ovf),       32'h2);
    chk("bp_vld",  32'(bm.word_vld),  32'h1);
    chk("bp_data", 32'(bm.word_data), 32'h11);
    word_rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp_data2", 32'(bm.word_data), 32'h22);
    chk("bp_vld2",  32'(bm.word_vld),  32'h1);
    chk("bp_lane2", 32'(bm.word_lane), 32'h1);
    @(posedge clk); #1;
    chk("bp_idle",      32'(bm.word_vld), 32'h0);
    chk("bp_ovf_stick", 32'(bm.ovf),      32'h2);
    @(negedge clk) clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    chk("bp_ovf_clr", 32'(bm.ovf), 32'h0);

    // Overflow set coinciding with clr_ovf: set wins on lane 2.
    word_rdy = 1'b0;
    send_word(2'd2, 8'h44);
    send_word(2'd2, 8'h55);
    p = 8'h66;
    for (int i = 7; i >= 1; i--) send_bit(2'd2, p[i]);
    clr_ovf = 1'b1;
    send_bit(2'd2, p[0]);
    clr_ovf = 1'b0;
    chk("ovf_set_wins", 32'(bm.ovf), 32'h4);

    // Lane 3 hold slot drained while lane 3 completes a new word: no overflow.
    do_reset();
    word_rdy = 1'b0;
    send_word(2'd3, 8'hC3);
    send_word(2'd3, 8'h3C);
    p = 8'hE7;
    for (int i = 7; i >= 1; i--) send_bit(2'd3, p[i]);
    chk("dc_held", 32'(bm.word_data), 32'hC3);
    word_rdy = 1'b1;
    send_bit(2'd3, p[0]);
    chk("dc_data1", 32'(bm.word_data), 32'h3C);
    chk("dc_lane1", 32'(bm.word_lane), 32'h3);
    @(posedge clk); #1;
    chk("dc_data2", 32'(bm.word_data), 32'hE7);
    chk("dc_vld2",  32'(bm.word_vld),  32'h1);
    @(posedge clk); #1;
    chk("dc_idle", 32'(bm.word_vld), 32'h0);
    chk("dc_ovf",  32'(bm.ovf),      32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
